// File: rtl/multiplexor_arbitrado_2a1.sv
// -----------------------------------------------------------------------------
// multiplexor_arbitrado_2a1
//
// Merges two valid/ready input channels into one registered output stream.
// Arbitration is round-robin. Each output word carries a one-hot source tag on
// Selector (01 = channel 1, 10 = channel 2, 00 = no word), so a downstream
// 1-to-2 demux can route it back by that tag.
//
// Ports:
//   Reloj         clock, rising edge
//   Reset         asynchronous, active-high reset
//   Entrada1/2    channel data (ANCHO bits)
//   Valido1/2     channel word valid
//   Listo1/2      channel word accepted this cycle (combinational grant)
//   Salida        registered output data
//   SalidaValida  output register holds a word
//   SalidaListo   downstream accepts the output word this cycle
//   Selector      source tag of Salida
// -----------------------------------------------------------------------------
module multiplexor_arbitrado_2a1 #(
    parameter int ANCHO = 8
) (
    input  logic             Reloj,
    input  logic             Reset,
    input  logic [ANCHO-1:0] Entrada1,
    input  logic             Valido1,
    output logic             Listo1,
    input  logic [ANCHO-1:0] Entrada2,
    input  logic             Valido2,
    output logic             Listo2,
    output logic [ANCHO-1:0] Salida,
    output logic             SalidaValida,
    input  logic             SalidaListo,
    output logic [1:0]       Selector
);

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    estado_t          estado_p0;
    logic             prioridad_p0;
    logic [ANCHO-1:0] salida_p0;
    logic [1:0]       selector_p0;
    logic             carga;

    // The output slot can take a new word when it is empty or being drained
    // in this same cycle; that is what gives back-to-back throughput.
    assign carga  = (estado_p0 == VACIO) | SalidaListo;

    // When both channels request, prioridad_p0 picks the winner (0 = ch1).
    // A lone requester always wins.
    assign Listo1 = carga & Valido1 & (~Valido2 | ~prioridad_p0);
    assign Listo2 = carga & Valido2 & (~Valido1 |  prioridad_p0);

    // ---- output register stage ----
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            estado_p0    <= VACIO;
            prioridad_p0 <= 1'b0;
            salida_p0    <= '0;
            selector_p0  <= 2'b00;
        end else if (Listo1) begin
            estado_p0    <= LLENO;
            prioridad_p0 <= 1'b1;
            salida_p0    <= Entrada1;
            selector_p0  <= 2'b01;
        end else if (Listo2) begin
            estado_p0    <= LLENO;
            prioridad_p0 <= 1'b0;
            salida_p0    <= Entrada2;
            selector_p0  <= 2'b10;
        end else if ((estado_p0 == LLENO) && SalidaListo) begin
            // Drained with nothing to replace it; data is left as don't-care.
            estado_p0    <= VACIO;
            selector_p0  <= 2'b00;
        end
    end

    assign Salida       = salida_p0;
    assign SalidaValida = (estado_p0 == LLENO);
    assign Selector     = selector_p0;

endmodule

// File: tb/tb_multiplexor_arbitrado_2a1.sv
module tb_multiplexor_arbitrado_2a1;

    localparam int ANCHO = 8;

    logic             Reloj;
    logic             Reset;
    logic [ANCHO-1:0] Entrada1;
    logic             Valido1;
    logic             Listo1;
    logic [ANCHO-1:0] Entrada2;
    logic             Valido2;
    logic             Listo2;
    logic [ANCHO-1:0] Salida;
    logic             SalidaValida;
    logic             SalidaListo;
    logic [1:0]       Selector;

    int n_cmp = 0;
    int n_err = 0;

    multiplexor_arbitrado_2a1 #(.ANCHO(ANCHO)) dut (
        .Reloj        (Reloj),
        .Reset        (Reset),
        .Entrada1     (Entrada1),
        .Valido1      (Valido1),
        .Listo1       (Listo1),
        .Entrada2     (Entrada2),
        .Valido2      (Valido2),
        .Listo2       (Listo2),
        .Salida       (Salida),
        .SalidaValida (SalidaValida),
        .SalidaListo  (SalidaListo),
        .Selector     (Selector)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Reloj);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic [1:0] s);
        chk({tag, ".Salida"}, 32'(Salida), 32'(d));
        chk({tag, ".SalidaValida"}, 32'(SalidaValida), 32'(v));
        chk({tag, ".Selector"}, 32'(Selector), 32'(s));
    endtask

    task automatic chk_listo(input string tag, input logic l1, input logic l2);
        chk({tag, ".Listo1"}, 32'(Listo1), 32'(l1));
        chk({tag, ".Listo2"}, 32'(Listo2), 32'(l2));
    endtask

    initial begin
        Reset = 1'b1; Entrada1 = '0; Valido1 = 1'b0; Entrada2 = '0; Valido2 = 1'b0;
        SalidaListo = 1'b0;
        tick(); tick();
        chk_out("reset", 8'h00, 1'b0, 2'b00);
        chk_listo("reset", 1'b0, 1'b0);

        // Single channel 1 word
        @(negedge Reloj);
        Reset = 1'b0;
        Valido1 = 1'b1; Entrada1 = 8'hA5; SalidaListo = 1'b1;
        #1;
        chk_listo("ch1_only", 1'b1, 1'b0);
        tick();
        chk_out("ch1_only_out", 8'hA5, 1'b1, 2'b01);

        // Consumed, nothing new
        Valido1 = 1'b0;
        #1;
        chk_listo("drain", 1'b0, 1'b0);
        tick();
        chk(("drain.SalidaValida"), 32'(SalidaValida), 32'd0);
        chk(("drain.Selector"), 32'(Selector), 32'd0);

        // Ch1 granted twice alone, then both valid: ch2 wins
        Valido1 = 1'b1; Entrada1 = 8'h01;
        tick();
        chk_out("ch1_a", 8'h01, 1'b1, 2'b01);
        Entrada1 = 8'h02;
        #1;
        chk_listo("ch1_b_grant", 1'b1, 1'b0);
        tick();
        chk_out("ch1_b", 8'h02, 1'b1, 2'b01);
        Entrada1 = 8'h11; Valido2 = 1'b1; Entrada2 = 8'h22;
        #1;
        chk_listo("prio_ch2", 1'b0, 1'b1);
        tick();
        chk_out("prio_ch2_out", 8'h22, 1'b1, 2'b10);

        // Round robin right after reset
        Reset = 1'b1;
        #1;
        chk_out("rst2", 8'h00, 1'b0, 2'b00);
        @(negedge Reloj);
        Reset = 1'b0;
        tick();
        chk_out("rr0", 8'h11, 1'b1, 2'b01);
        tick();
        chk_out("rr1", 8'h22, 1'b1, 2'b10);
        tick();
        chk_out("rr2", 8'h11, 1'b1, 2'b01);
        tick();
        chk_out("rr3", 8'h22, 1'b1, 2'b10);

        // Load 33 from ch2 (only ch2 valid), then hold under backpressure
        Valido1 = 1'b0; Entrada2 = 8'h33;
        tick();
        chk_out("hold_load", 8'h33, 1'b1, 2'b10);
        SalidaListo = 1'b0;
        Valido1 = 1'b1; Entrada1 = 8'h44; Entrada2 = 8'h55;
        #1;
        chk_listo("bp0", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp_hold", 8'h33, 1'b1, 2'b10);
            chk_listo("bp_hold", 1'b0, 1'b0);
        end
        SalidaListo = 1'b1;
        #1;
        chk_listo("bp_release", 1'b1, 1'b0);
        tick();
        chk_out("bp_release_out", 8'h44, 1'b1, 2'b01);

        // Async reset mid-cycle with a held word pending (prio is now 1)
        SalidaListo = 1'b0;
        #1;
        chk_listo("pend", 1'b0, 1'b0);
        #1;
        Reset = 1'b1;
        #1;
        chk_out("async_rst", 8'h00, 1'b0, 2'b00);
        Valido1 = 1'b0; Valido2 = 1'b0;
        @(negedge Reloj);
        Reset = 1'b0;
        Valido1 = 1'b1; Valido2 = 1'b1; Entrada1 = 8'h66; Entrada2 = 8'h77;
        SalidaListo = 1'b1;
        #1;
        chk_listo("post_rst_prio", 1'b1, 1'b0);
        tick();
        chk_out("post_rst_out", 8'h66, 1'b1, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiplexor_arbitrado_2a1.md
Name: multiplexor_arbitrado_2a1

Overview:
- Merge counterpart of the 1-to-2 demultiplexor: collects words from two input channels into one output stream.
- Each input channel has a valid/ready handshake. Arbitration between channels is round-robin.
- Each output word is tagged with its source on Selector, using the same one-hot encoding as the demux: 2'b01 = channel 1, 2'b10 = channel 2.
- The output stage is a single registered entry (register slice), so a downstream demux can route the word back by its tag.

Parameters:
ANCHO, 8, data width in bits of each input channel and of the output.

Ports:
Reloj  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Entrada1  input  ANCHO  channel 1 data
Valido1  input  1  channel 1 word valid
Listo1  output  1  channel 1 word accepted this cycle (combinational)
Entrada2  input  ANCHO  channel 2 data
Valido2  input  1  channel 2 word valid
Listo2  output  1  channel 2 word accepted this cycle (combinational)
Salida  output  ANCHO  registered output data
SalidaValida  output  1  output register holds a word
SalidaListo  input  1  downstream accepts the output word this cycle
Selector  output  2  source tag of Salida: 01 = ch1, 10 = ch2, 00 = empty

Behaviour:
- Reset (async, Reset=1), held while asserted:
  - Salida = 0, SalidaValida = 0, Selector = 2'b00.
  - Internal Prioridad = 0, i.e. channel 1 preferred.
- Two-state FSM, encoded by SalidaValida:
  - VACIO -> LLENO when a grant occurs.
  - LLENO -> VACIO when SalidaListo=1 and no new grant.
  - LLENO -> LLENO when SalidaListo=1 with a new grant (back-to-back), or when SalidaListo=0.
- Carga = !SalidaValida | SalidaListo. The output register may load only when Carga=1.
- Grants, combinational, at most one per cycle:
  - Listo1 = Carga & Valido1 & (!Valido2 | Prioridad==0).
  - Listo2 = Carga & Valido2 & (!Valido1 | Prioridad==1).
  - A transfer on channel k occurs when Listok=1 (Validok is already included).
- On a grant at rising edge: Salida <= Entradak, Selector <= one-hot(k), SalidaValida <= 1.
- Prioridad update:
  - After a channel 1 grant: Prioridad <= 1.
  - After a channel 2 grant: Prioridad <= 0.
  - No grant: Prioridad unchanged.
- Both channels continuously valid: grants alternate ch1, ch2, ch1, ...
- Only one channel valid: it is granted every cycle Carga=1, regardless of Prioridad.
- Latency: 1 cycle from input transfer to SalidaValida. Throughput: 1 word/cycle with SalidaListo held at 1.
- Backpressure: while SalidaValida=1 and SalidaListo=0, Salida and Selector are held stable and Listo1 = Listo2 = 0.
- Output consumed with no grant: SalidaValida <= 0 and Selector <= 2'b00. Salida keeps its last value (don't-care).
- SalidaListo=1 while SalidaValida=0: no effect.
- Selector is never 2'b11. Selector = 2'b00 exactly when SalidaValida = 0.
- Reset mid-operation: any held word is discarded with no output transfer, and Prioridad returns to 0.
- Inputs are not required to hold Validok once asserted. The block does not check this.

Test Plan:
- Reset asserted asynchronously mid-cycle with SalidaValida=1 -> outputs go to 0 / 0 / 2'b00 immediately, without waiting for a clock edge; Listo1 = Listo2 = 0 while the held word is pending.
- Only Valido1=1, Entrada1=8'hA5, SalidaListo=1 -> Listo1=1 in the same cycle; next cycle Salida=8'hA5, Selector=2'b01, SalidaValida=1.
- Both valid every cycle, Entrada1=8'h11, Entrada2=8'h22, SalidaListo=1, starting right after reset -> output sequence 11/01, 22/10, 11/01, 22/10, one word per cycle.
- Word 8'h33 from ch2 held, SalidaListo=0 for 3 cycles with both inputs valid -> Salida=8'h33 and Selector=2'b10 stable; Listo1 = Listo2 = 0. SalidaListo=1 then loads the ch1 word in that same cycle.
- SalidaValida=1, SalidaListo=1, no input valid -> next cycle SalidaValida=0 and Selector=2'b00.
- Ch1 alone granted twice, then both valid -> ch2 granted first (Prioridad=1 after the ch1 grants).
